fir_tap_scheduler: RTL and testbench

Sequencer for the five-lane complex FIR accumulator. Accepts one input sample at a time and writes it into the circular delay-line RAM. It then walks the tap set in groups of five: one read-address group per cycle, plus a coefficient-group index. It drives the accumulator's valid (first-group) strobe so each output sample restarts accumulation, and it tracks accumulator drain so upstream logic knows when the filter is quiescent.

---
 rtl/fir_tap_scheduler.sv | 128 ++++++++++++
 tb/tb_fir_tap_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_scheduler.sv
// Sequencer for the five-lane complex FIR accumulator: writes each accepted sample
// into the circular delay line, then issues NG read groups and tracks accumulator drain.
module fir_tap_scheduler #(
  parameter int NTAPS = 25,
  parameter int AW    = 5,
  parameter int GW    = 3,
  parameter int DRAIN = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pushIn,
  output logic          readyOut,
  output logic          wrEn,
  output logic [AW-1:0] wrAddr,
  output logic          rdEn,
  output logic [AW-1:0] rdBase,
  output logic [GW-1:0] coefGrp,
  output logic          firstOut,
  output logic          lastOut,
  output logic          idleOut,
  output logic [15:0]   sampleCnt
);

  localparam int NG = NTAPS / 5;
  localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RUN} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_base;
  logic [GW-1:0]   r_grp;
  logic [DW-1:0]   r_drain;
  logic            r_wrEn;
  logic [AW-1:0]   r_wrAddr;
  logic            r_rdEn;
  logic [AW-1:0]   r_rdBase;
  logic [GW-1:0]   r_coefGrp;
  logic            r_firstOut;
  logic            r_lastOut;
  logic            r_idleOut;
  logic [15:0]     r_sampleCnt;

  logic            w_lastGrp;
  logic            w_accept;
  logic [AW-1:0]   w_grpOffset;

  assign w_lastGrp   = (r_state == S_RUN) && (r_grp == GW'(NG - 1));
  assign readyOut    = !reset && ((r_state == S_IDLE) || w_lastGrp);
  assign w_accept    = pushIn && readyOut;
  // Each group steps five samples further back in the delay line; wraps mod 2^AW.
  assign w_grpOffset = AW'(r_grp) * AW'(5);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wrPtr     <= '0;
      r_base      <= '0;
      r_grp       <= '0;
      r_drain     <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_rdEn      <= 1'b0;
      r_rdBase    <= '0;
      r_coefGrp   <= '0;
      r_firstOut  <= 1'b0;
      r_lastOut   <= 1'b0;
      r_idleOut   <= 1'b1;
      r_sampleCnt <= '0;
    end else begin
      r_wrEn     <= 1'b0;
      r_rdEn     <= 1'b0;
      r_firstOut <= 1'b0;
      r_lastOut  <= 1'b0;
      r_idleOut  <= (r_state == S_IDLE) && (r_drain == '0);

      // Drain restarts on the last group so idle waits for the final result to leave.
      if (w_lastGrp) begin
        r_drain <= DW'(DRAIN);
      end else if (r_drain != '0) begin
        r_drain <= r_drain - DW'(1);
      end

      if (w_accept) begin
        r_base      <= r_wrPtr;
        r_sampleCnt <= r_sampleCnt + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_wrEn   <= 1'b1;
          r_wrAddr <= r_base;
          r_wrPtr  <= r_wrPtr + AW'(1);
          r_grp    <= '0;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_rdEn     <= 1'b1;
          r_coefGrp  <= r_grp;
          r_rdBase   <= r_base - w_grpOffset;
          r_firstOut <= (r_grp == '0);
          r_lastOut  <= w_lastGrp;
          if (w_lastGrp) begin
            r_grp   <= '0;
            r_state <= w_accept ? S_WRITE : S_IDLE;
          end else begin
            r_grp <= r_grp + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wrEn      = r_wrEn;
  assign wrAddr    = r_wrAddr;
  assign rdEn      = r_rdEn;
  assign rdBase    = r_rdBase;
  assign coefGrp   = r_coefGrp;
  assign firstOut  = r_firstOut;
  assign lastOut   = r_lastOut;
  assign idleOut   = r_idleOut;
  assign sampleCnt = r_sampleCnt;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Self-checking bench for fir_tap_scheduler: a timing-model scoreboard checks every
// write/read group, plus a per-cycle vector table and hand-written corner sequences.
module tb_fir_tap_scheduler;

  localparam int NTAPS = 25;
  localparam int AW    = 5;
  localparam int GW    = 3;
  localparam int DRAIN = 6;
  localparam int NG    = NTAPS / 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pushIn = 1'b0;
  logic          readyOut;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic          rdEn;
  logic [AW-1:0] rdBase;
  logic [GW-1:0] coefGrp;
  logic          firstOut;
  logic          lastOut;
  logic          idleOut;
  logic [15:0]   sampleCnt;

  int checks = 0;
  int failures = 0;

  fir_tap_scheduler #(.NTAPS(NTAPS), .AW(AW), .GW(GW), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset(reset), .pushIn(pushIn), .readyOut(readyOut),
    .wrEn(wrEn), .wrAddr(wrAddr), .rdEn(rdEn), .rdBase(rdBase),
    .coefGrp(coefGrp), .firstOut(firstOut), .lastOut(lastOut),
    .idleOut(idleOut), .sampleCnt(sampleCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [GW-1:0] grp;
    bit            first;
    bit            last;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];

  int            cyc = 0;
  int            lastAcc = 0;
  bit            noAccept = 1'b1;
  bit            mRstEdge = 1'b1;
  bit            mIdleExp = 1'b1;
  logic [AW-1:0] mWrPtr = '0;
  logic [15:0]   mCnt = '0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit p);
    pushIn = p;
    @(negedge clk);
  endtask

  // Timing model: a sample accepted at edge t writes at t+1, reads groups at t+2..t+1+NG,
  // the scheduler is ready again from edge t+NG+1, and idle reappears at t+NG+2+DRAIN.
  always @(posedge clk) begin
    int   t;
    exp_t e;
    t = cyc + 1;
    cyc <= t;
    mRstEdge <= reset;
    if (reset) begin
      wq.delete();
      rq.delete();
      noAccept <= 1'b1;
      mWrPtr   <= '0;
      mCnt     <= '0;
      mIdleExp <= 1'b1;
    end else begin
      mIdleExp <= noAccept || (t >= lastAcc + NG + 2 + DRAIN);
      if (pushIn && (noAccept || t >= lastAcc + NG + 1)) begin
        e.cyc = t + 1; e.addr = mWrPtr; e.grp = '0; e.first = 0; e.last = 0;
        wq.push_back(e);
        for (int g = 0; g < NG; g++) begin
          e.cyc   = t + 2 + g;
          e.addr  = mWrPtr - AW'(5 * g);
          e.grp   = GW'(g);
          e.first = (g == 0);
          e.last  = (g == NG - 1);
          rq.push_back(e);
        end
        lastAcc  <= t;
        noAccept <= 1'b0;
        mWrPtr   <= mWrPtr + AW'(1);
        mCnt     <= mCnt + 16'd1;
      end
    end
  end

  // Scoreboard consumer, sampled just after the falling edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset && !mRstEdge) begin
      checkOutput("readyOut", readyOut, int'(noAccept || (cyc + 1 >= lastAcc + NG + 1)));
      checkOutput("idleOut", idleOut, mIdleExp);
      checkOutput("sampleCnt", sampleCnt, mCnt);
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        e = wq.pop_front();
        checkOutput("wrEn_missing_cycle", cyc, e.cyc);
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        e = rq.pop_front();
        checkOutput("rdEn_missing_cycle", cyc, e.cyc);
      end
      if (wrEn) begin
        if (wq.size() == 0) checkOutput("wrEn_unexpected", wrEn, 0);
        else begin
          e = wq.pop_front();
          checkOutput("wrEn_cycle", cyc, e.cyc);
          checkOutput("wrAddr", wrAddr, e.addr);
        end
      end
      if (rdEn) begin
        if (rq.size() == 0) checkOutput("rdEn_unexpected", rdEn, 0);
        else begin
          e = rq.pop_front();
          checkOutput("rdEn_cycle", cyc, e.cyc);
          checkOutput("rdBase", rdBase, e.addr);
          checkOutput("coefGrp", coefGrp, e.grp);
          checkOutput("firstOut", firstOut, e.first);
          checkOutput("lastOut", lastOut, e.last);
        end
      end else begin
        checkOutput("first_last_without_rdEn", int'(firstOut | lastOut), 0);
      end
    end
  end

  typedef struct {
    bit            push;
    bit            wrEn;
    bit            rdEn;
    logic [AW-1:0] addr;
    logic [AW-1:0] base;
    logic [GW-1:0] grp;
    bit            first;
    bit            last;
    bit            idle;
    bit            ready;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Single sample right after reset: row k is the cycle following edge k.
    vecs[0] = '{1, 0, 0, 0, 0,  0, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 1, 0, 0,  0, 1, 0, 0, 0};
    vecs[3] = '{0, 0, 1, 0, 27, 1, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 0, 22, 2, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 1, 0, 17, 3, 0, 0, 0, 1};
    vecs[6] = '{0, 0, 1, 0, 12, 4, 0, 1, 0, 1};
    for (int i = 7; i < 13; i++) vecs[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    reset = 1'b1;
    pushIn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_readyOut", readyOut, 0);
    checkOutput("rst_wrEn", wrEn, 0);
    checkOutput("rst_rdEn", rdEn, 0);
    checkOutput("rst_wrAddr", wrAddr, 0);
    checkOutput("rst_rdBase", rdBase, 0);
    checkOutput("rst_coefGrp", coefGrp, 0);
    checkOutput("rst_sampleCnt", sampleCnt, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idleOut", idleOut, 1);
    checkOutput("post_rst_readyOut", readyOut, 1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].push);
      checkOutput($sformatf("tbl%0d_wrEn", i), wrEn, vecs[i].wrEn);
      checkOutput($sformatf("tbl%0d_rdEn", i), rdEn, vecs[i].rdEn);
      checkOutput($sformatf("tbl%0d_firstOut", i), firstOut, vecs[i].first);
      checkOutput($sformatf("tbl%0d_lastOut", i), lastOut, vecs[i].last);
      checkOutput($sformatf("tbl%0d_idleOut", i), idleOut, vecs[i].idle);
      checkOutput($sformatf("tbl%0d_readyOut", i), readyOut, vecs[i].ready);
      if (vecs[i].wrEn) checkOutput($sformatf("tbl%0d_wrAddr", i), wrAddr, vecs[i].addr);
      if (vecs[i].rdEn) begin
        checkOutput($sformatf("tbl%0d_rdBase", i), rdBase, vecs[i].base);
        checkOutput($sformatf("tbl%0d_coefGrp", i), coefGrp, vecs[i].grp);
      end
    end
    checkOutput("tbl_sampleCnt", sampleCnt, 1);

    // Back-to-back: three accepts at relative edges 0, 6, 12; the third writes address 3.
    pushIn = 1'b1;
    repeat (13) @(negedge clk);
    pushIn = 1'b0;
    @(negedge clk);
    checkOutput("b2b_wrEn3", wrEn, 1);
    checkOutput("b2b_wrAddr3", wrAddr, 3);
    repeat (20) @(negedge clk);

    // Backpressure: push requested at t+3 is held off until the last group at t+6.
    applyStimulus(1'b1);
    pushIn = 1'b0;
    repeat (2) @(negedge clk);
    pushIn = 1'b1;
    repeat (4) @(negedge clk);
    pushIn = 1'b0;
    @(negedge clk);
    checkOutput("bp_wrEn_t7", wrEn, 1);
    checkOutput("bp_wrAddr_t7", wrAddr, 5);
    repeat (20) @(negedge clk);

    // Pointer wrap: 34 back-to-back samples carry the write pointer past 31.
    pushIn = 1'b1;
    repeat (34 * (NG + 1) - 5) @(negedge clk);
    pushIn = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("wrap_sampleCnt", sampleCnt, 1 + 3 + 2 + 34);

    // Reset while group 2 is on the outputs.
    applyStimulus(1'b1);
    pushIn = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rstmid_rdEn_grp2", rdEn, 1);
    checkOutput("rstmid_coefGrp2", coefGrp, 2);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_readyOut_in_reset", readyOut, 0);
    @(negedge clk);
    checkOutput("rstmid_rdEn", rdEn, 0);
    checkOutput("rstmid_wrEn", wrEn, 0);
    checkOutput("rstmid_firstOut", firstOut, 0);
    checkOutput("rstmid_lastOut", lastOut, 0);
    checkOutput("rstmid_rdBase", rdBase, 0);
    checkOutput("rstmid_coefGrp", coefGrp, 0);
    checkOutput("rstmid_wrAddr", wrAddr, 0);
    checkOutput("rstmid_sampleCnt", sampleCnt, 0);
    checkOutput("rstmid_readyOut", readyOut, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_idleOut_after", idleOut, 1);
    applyStimulus(1'b1);
    pushIn = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_restart_wrEn", wrEn, 1);
    checkOutput("rstmid_restart_wrAddr", wrAddr, 0);
    repeat (20) @(negedge clk);

    checkOutput("scoreboard_drained", wq.size() + rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
